// File: rtl/axis_acq_sequencer.sv
// Trigger-driven acquisition sequencer: arms on command, waits for a trigger edge, skips a
// post-trigger delay, then writes a fixed number of stream samples into a FIFO write port.
module axis_acq_sequencer #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_arm,
  input  logic                        cfg_abort,
  input  logic [CNTR_WIDTH-1:0]       cfg_len,
  input  logic [CNTR_WIDTH-1:0]       cfg_delay,
  input  logic                        trig_in,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        fifo_write_full,
  output logic [AXIS_TDATA_WIDTH-1:0] fifo_write_data,
  output logic                        fifo_write_wren,
  output logic [2:0]                  sts_state,
  output logic [CNTR_WIDTH-1:0]       sts_count,
  output logic                        sts_overflow,
  output logic                        done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                      state_q;
  logic [CNTR_WIDTH-1:0]       len_q;
  logic [CNTR_WIDTH-1:0]       delay_q;
  logic [CNTR_WIDTH-1:0]       dly_cnt_q;
  logic [CNTR_WIDTH-1:0]       count_q;
  logic [AXIS_TDATA_WIDTH-1:0] data_q;
  logic                        trig_prev_q;
  logic                        pend_q;
  logic                        ovf_q;
  logic                        done_q;

  logic                        trig_edge_d;
  logic                        drop_d;
  logic [CNTR_WIDTH-1:0]       dly_cnt_inc_d;
  logic [CNTR_WIDTH-1:0]       count_inc_d;

  assign trig_edge_d   = trig_in & ~trig_prev_q;
  assign dly_cnt_inc_d = dly_cnt_q + CNTR_WIDTH'(1);
  assign count_inc_d   = count_q + CNTR_WIDTH'(1);
  // An abort cancels the write pending in the same cycle, so it can neither issue nor overflow.
  assign drop_d        = pend_q & fifo_write_full & ~cfg_abort;

  assign s_axis_tready   = 1'b1;
  assign fifo_write_data = data_q;
  assign fifo_write_wren = pend_q & ~fifo_write_full & ~cfg_abort;
  assign sts_state       = 3'(state_q);
  assign sts_count       = count_q;
  assign sts_overflow    = ovf_q;
  assign done            = done_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      delay_q     <= '0;
      dly_cnt_q   <= '0;
      count_q     <= '0;
      data_q      <= '0;
      trig_prev_q <= 1'b1;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      trig_prev_q <= trig_in;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      if (drop_d) ovf_q <= 1'b1;
      if (cfg_abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (cfg_arm) begin
              state_q <= S_ARMED;
              len_q   <= cfg_len;
              delay_q <= cfg_delay;
              count_q <= '0;
              ovf_q   <= 1'b0;
            end
          end
          S_ARMED: begin
            if (trig_edge_d) begin
              dly_cnt_q <= '0;
              if (delay_q != '0) begin
                state_q <= S_DELAY;
              end else if (len_q == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_CAPTURE;
              end
            end
          end
          S_DELAY: begin
            if (s_axis_tvalid) begin
              dly_cnt_q <= dly_cnt_inc_d;
              if (dly_cnt_inc_d == delay_q) begin
                if (len_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_CAPTURE;
                end
              end
            end
          end
          S_CAPTURE: begin
            // Every taken sample overwrites the write register; it is never stalled.
            if (s_axis_tvalid) begin
              data_q  <= s_axis_tdata;
              pend_q  <= 1'b1;
              count_q <= count_inc_d;
              if (count_inc_d == len_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
